icache: RTL and testbench

Direct-mapped, read-only instruction cache between `prefetch_queue` and the shared memory bus. It serves 64-bit aligned instruction blocks to the prefetch queue. It converts misses into single outstanding `BUS_LOAD` requests using the tagged memory response protocol. It fills the line and forwards the data on the cycle the tagged data returns.

---
 rtl/icache.sv | 111 +++++++++++
 tb/tb_icache.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with one outstanding
// tagged BUS_LOAD. A fill writes the line and forwards the block to the
// prefetch queue when it still wants that block.
module icache #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned LINES = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] proc2Icache_addr,
    input  logic            bus_grant,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [1:0]      proc2Imem_command,
    output logic [XLEN-1:0] proc2Imem_addr,
    output logic [63:0]     Icache2proc_data,
    output logic            Icache2proc_valid
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = XLEN - 3 - IDX_W;

    localparam logic [1:0] BUS_NONE = 2'h0;
    localparam logic [1:0] BUS_LOAD = 2'h1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             r_state;
    logic [3:0]         r_pend_tag;
    logic [XLEN-1:0]    r_pend_addr;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tags [LINES];
    logic [63:0]        r_data [LINES];

    logic [XLEN-1:0]    w_aligned;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_pend_idx;
    logic [TAG_W-1:0]   w_pend_tagv;
    logic               w_hit;
    logic               w_fill;
    logic               w_fwd;
    logic               w_req;

    // Masking (rather than slicing) drops the byte offset so every address bit is consumed.
    assign w_aligned   = proc2Icache_addr & {{(XLEN-3){1'b1}}, 3'b000};
    assign w_idx       = w_aligned[3 +: IDX_W];
    assign w_tag       = w_aligned[XLEN-1 : 3+IDX_W];
    assign w_pend_idx  = r_pend_addr[3 +: IDX_W];
    assign w_pend_tagv = r_pend_addr[XLEN-1 : 3+IDX_W];

    assign w_hit  = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    assign w_fill = (r_state == S_WAIT) && (mem2proc_tag == r_pend_tag);
    assign w_fwd  = w_fill && (r_pend_addr == w_aligned);
    assign w_req  = (r_state == S_IDLE) && !w_hit && bus_grant && !reset;

    // Combinational hit/forward response and bus request; all quiet during reset.
    always_comb begin
        Icache2proc_valid = 1'b0;
        Icache2proc_data  = '0;
        proc2Imem_command = BUS_NONE;
        proc2Imem_addr    = '0;
        if (!reset) begin
            if (w_fwd) begin
                Icache2proc_valid = 1'b1;
                Icache2proc_data  = mem2proc_data;
            end else if (w_hit) begin
                Icache2proc_valid = 1'b1;
                Icache2proc_data  = r_data[w_idx];
            end
            if (w_req) begin
                proc2Imem_command = BUS_LOAD;
                proc2Imem_addr    = w_aligned;
            end
        end
    end

    // Miss FSM: latch the accepted transaction, then fill the line when its tag returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pend_tag  <= '0;
            r_pend_addr <= '0;
            r_valid     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && (mem2proc_response != 4'd0)) begin
                        r_pend_tag  <= mem2proc_response;
                        r_pend_addr <= w_aligned;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_fill) begin
                        r_valid[w_pend_idx] <= 1'b1;
                        r_tags[w_pend_idx]  <= w_pend_tagv;
                        r_data[w_pend_idx]  <= mem2proc_data;
                        r_state             <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed vectors for icache; a driver pushes the expected
// per-cycle response into a queue and a monitor pops and compares it.
module tb_icache;

    localparam logic [1:0] NONE = 2'h0;
    localparam logic [1:0] LOAD = 2'h1;

    localparam logic [63:0] D100  = 64'hDEAD_BEEF_0000_0013;
    localparam logic [63:0] D208  = 64'hA5A5_0000_0000_0208;
    localparam logic [63:0] D200  = 64'h0123_4567_89AB_0200;
    localparam logic [63:0] D100B = 64'hCAFE_F00D_0000_0100;
    localparam logic [63:0] D400  = 64'h0000_4444_0000_0400;
    localparam logic [63:0] D310  = 64'h3131_3131_3131_3131;
    localparam logic [63:0] JUNK  = 64'h1111_2222_3333_4444;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] proc2Icache_addr = '0;
    logic        bus_grant = 1'b0;
    logic [3:0]  mem2proc_response = '0;
    logic [63:0] mem2proc_data = '0;
    logic [3:0]  mem2proc_tag = '0;
    logic [1:0]  proc2Imem_command;
    logic [31:0] proc2Imem_addr;
    logic [63:0] Icache2proc_data;
    logic        Icache2proc_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        ev;
        logic [63:0] ed;
        logic [1:0]  ec;
        logic [31:0] ea;
    } exp_t;

    exp_t q[$];

    icache #(.XLEN(32), .LINES(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .proc2Icache_addr  (proc2Icache_addr),
        .bus_grant         (bus_grant),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .proc2Imem_command (proc2Imem_command),
        .proc2Imem_addr    (proc2Imem_addr),
        .Icache2proc_data  (Icache2proc_data),
        .Icache2proc_valid (Icache2proc_valid)
    );

    always #5 clock = ~clock;

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (Icache2proc_valid !== e.ev || Icache2proc_data !== e.ed ||
                proc2Imem_command !== e.ec || proc2Imem_addr !== e.ea) begin
                errors++;
                $display("FAIL %s: got valid=%0b data=%h cmd=%0d addr=%h, expected valid=%0b data=%h cmd=%0d addr=%h",
                         e.name, Icache2proc_valid, Icache2proc_data, proc2Imem_command, proc2Imem_addr,
                         e.ev, e.ed, e.ec, e.ea);
            end
        end
    end

    task automatic step(input logic rst, input logic [31:0] addr, input logic grant,
                        input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] data,
                        input logic ev, input logic [63:0] ed, input logic [1:0] ec,
                        input logic [31:0] ea, input string name);
        exp_t e;
        reset             = rst;
        proc2Icache_addr  = addr;
        bus_grant         = grant;
        mem2proc_response = resp;
        mem2proc_tag      = tag;
        mem2proc_data     = data;
        e.name = name; e.ev = ev; e.ed = ed; e.ec = ec; e.ea = ea;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clock);
        #1;
        // Reset cycle: outputs quiet even with a miss, grant and response present.
        step(1, 32'h100, 1, 3, 0, '0,    0, '0,   NONE, 32'h0,   "reset");
        // Cold miss on 0x100, tag 3 returns two cycles after the request.
        step(0, 32'h100, 1, 3, 0, '0,    0, '0,   LOAD, 32'h100, "cold_req");
        step(0, 32'h100, 1, 0, 0, '0,    0, '0,   NONE, 32'h0,   "cold_wait");
        step(0, 32'h100, 1, 0, 3, D100,  1, D100, NONE, 32'h0,   "cold_fill");
        step(0, 32'h104, 1, 0, 3, JUNK,  1, D100, NONE, 32'h0,   "hit_104");
        // Rejections and lost grant before acceptance with response 5.
        step(0, 32'h208, 1, 0, 0, '0,    0, '0,   LOAD, 32'h208, "rej1");
        step(0, 32'h208, 1, 0, 0, '0,    0, '0,   LOAD, 32'h208, "rej2");
        step(0, 32'h208, 0, 5, 0, '0,    0, '0,   NONE, 32'h0,   "nogrant");
        step(0, 32'h208, 1, 5, 0, '0,    0, '0,   LOAD, 32'h208, "accept5");
        step(0, 32'h208, 1, 0, 3, JUNK,  0, '0,   NONE, 32'h0,   "wait5_stray3");
        step(0, 32'h208, 1, 0, 5, D208,  1, D208, NONE, 32'h0,   "fill5");
        // Fastest memory (tag in R+1) on 0x200, evicting 0x100 from idx 0.
        step(0, 32'h200, 1, 7, 0, '0,    0, '0,   LOAD, 32'h200, "evict_req");
        step(0, 32'h200, 1, 0, 7, D200,  1, D200, NONE, 32'h0,   "fast_fill");
        step(0, 32'h20C, 1, 9, 0, '0,    1, D208, NONE, 32'h0,   "hit_20c");
        step(0, 32'h100, 1, 2, 0, '0,    0, '0,   LOAD, 32'h100, "evict_miss100");
        // Redirect to 0x400 while 0x100 (tag 2) is outstanding.
        step(0, 32'h400, 1, 0, 0, '0,    0, '0,   NONE, 32'h0,   "redirect_wait");
        step(0, 32'h400, 1, 0, 2, D100B, 0, '0,   NONE, 32'h0,   "redirect_fill");
        step(0, 32'h400, 1, 4, 0, '0,    0, '0,   LOAD, 32'h400, "redirect_req");
        // Stray tags while pend_tag=4.
        step(0, 32'h400, 1, 0, 0, JUNK,  0, '0,   NONE, 32'h0,   "stray0");
        step(0, 32'h400, 1, 0, 1, JUNK,  0, '0,   NONE, 32'h0,   "stray1");
        step(0, 32'h400, 1, 0, 7, JUNK,  0, '0,   NONE, 32'h0,   "stray7");
        step(0, 32'h100, 1, 0, 0, '0,    1, D100B, NONE, 32'h0,  "hit_100_redirected");
        step(0, 32'h400, 1, 0, 4, D400,  1, D400, NONE, 32'h0,   "fill4");
        // Reset while waiting on tag 6; the late tag must not fill.
        step(0, 32'h310, 1, 6, 0, '0,    0, '0,   LOAD, 32'h310, "rw_req");
        step(1, 32'h310, 1, 0, 0, '0,    0, '0,   NONE, 32'h0,   "rw_reset");
        step(0, 32'h310, 0, 0, 6, D310,  0, '0,   NONE, 32'h0,   "rw_late_tag6");
        step(0, 32'h310, 1, 0, 0, '0,    0, '0,   LOAD, 32'h310, "rw_miss");
        step(0, 32'h104, 1, 0, 0, '0,    0, '0,   LOAD, 32'h100, "post_reset_104");
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
